// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Imported by instr_fetch and fetch_wait_ctr.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    function automatic logic [15:0] sat_inc16(
        input logic [15:0] v
    );
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_wait_ctr.sv
// Loadable down-counter timing the memory read settle window.
// Stops at zero; zero flag tells fetch the word is usable.
module fetch_wait_ctr
    import fetch_pkg::*;
(
    input  logic             clk,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, memory wait, registered word to decode,
// branch redirect and end-of-program halt.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned RD_CYCLES = 2,
    parameter int unsigned MEM_SIZE  = 40,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [31:0]        mem_addr,
    input  logic [INSTR_W-1:0] mem_instr,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [31:0]        instr_pc,
    input  logic               redirect_en,
    input  logic [31:0]        redirect_pc,
    output logic               halted,
    output logic [15:0]        fetch_count
);

    localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(RD_CYCLES - 1);
    localparam logic [31:0]      MEM_LIM = 32'(MEM_SIZE);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_inc;
    logic [31:0]  tgt;
    logic         xfer;
    logic         ctr_load;
    logic         ctr_en;
    logic         ctr_zero;

    assign mem_addr = pc;
    assign pc_inc   = pc + 32'(PC_STEP);
    assign tgt      = {redirect_pc[31:2], 2'b00};
    assign xfer     = (state == HOLD) && instr_valid && instr_ready;
    assign ctr_load = !rst_n || redirect_en || xfer;
    assign ctr_en   = (state == FETCH);

    fetch_wait_ctr u_wait (
        .clk      (clk),
        .load     (ctr_load),
        .load_val (RELOAD),
        .en       (ctr_en),
        .zero     (ctr_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            // decode already took the word, so it counts even on redirect
            if (xfer) begin
                fetch_count <= sat_inc16(fetch_count);
            end
            if (redirect_en) begin
                pc          <= tgt;
                instr_valid <= 1'b0;
                if (tgt < MEM_LIM) begin
                    state  <= FETCH;
                    halted <= 1'b0;
                end else begin
                    state  <= HALT;
                    halted <= 1'b1;
                end
            end else begin
                unique case (state)
                    FETCH: begin
                        if (ctr_zero) begin
                            instr       <= mem_instr;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (instr_ready) begin
                            instr_valid <= 1'b0;
                            pc          <= pc_inc;
                            if (pc_inc >= MEM_LIM) begin
                                state  <= HALT;
                                halted <= 1'b1;
                            end else begin
                                state <= FETCH;
                            end
                        end
                    end
                    HALT: begin
                        halted <= 1'b1;
                    end
                    default: begin
                        state <= FETCH;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a transfer scoreboard.
// Behavioural memory answers combinationally from mem_addr.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_instr;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_pc;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        halted;
    logic [15:0] fetch_count;

    int checks;
    int failures;
    logic [31:0] sb_q[$];

    instr_fetch #(
        .RD_CYCLES (2),
        .MEM_SIZE  (40),
        .RESET_PC  (32'd0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_addr    (mem_addr),
        .mem_instr   (mem_instr),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_pc    (instr_pc),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        case (a)
            32'h00:  return 32'h58000000;
            32'h04:  return 32'h58080003;
            32'h08:  return 32'h40008000;
            default: return {16'hA5A5, a[15:0]};
        endcase
    endfunction

    assign mem_instr = word_at(mem_addr);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n;
        n = 0;
        while (!instr_valid && n < max) begin
            step(1);
            n++;
        end
        chk(tag, {31'd0, instr_valid}, 32'd1);
    endtask

    // A transfer happens at the next edge; inputs are stable here.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && instr_valid && instr_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_extra", 32'd1, 32'd0);
            end else begin
                logic [31:0] epc;
                epc = sb_q.pop_front();
                chk("sb_pc", instr_pc, epc);
                chk("sb_instr", instr, word_at(epc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        instr_ready = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = 32'd0;
        step(2);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_ipc", instr_pc, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_fc", {16'd0, fetch_count}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);

        rst_n = 1'b1;
        sb_q.push_back(32'h00);
        step(1);
        chk("lat1_valid", {31'd0, instr_valid}, 32'd0);
        step(1);
        chk("lat2_valid", {31'd0, instr_valid}, 32'd1);
        chk("w0_instr", instr, 32'h58000000);
        chk("w0_pc", instr_pc, 32'd0);
        step(1);
        chk("x0_fc", {16'd0, fetch_count}, 32'd1);
        chk("x0_valid", {31'd0, instr_valid}, 32'd0);
        chk("x0_addr", mem_addr, 32'h04);

        redirect_en = 1'b1;
        redirect_pc = 32'h0000000B;
        sb_q.push_back(32'h08);
        step(1);
        redirect_en = 1'b0;
        chk("rd_addr", mem_addr, 32'h08);
        chk("rd_valid", {31'd0, instr_valid}, 32'd0);
        step(1);
        chk("rd_lat_valid", {31'd0, instr_valid}, 32'd0);
        step(1);
        chk("rd_w_valid", {31'd0, instr_valid}, 32'd1);
        chk("rd_w_instr", instr, 32'h40008000);
        chk("rd_w_pc", instr_pc, 32'h08);
        step(1);
        chk("x1_fc", {16'd0, fetch_count}, 32'd2);

        instr_ready = 1'b0;
        wait_valid("hold_valid", 8);
        chk("hold_pc0", instr_pc, 32'h0C);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("hold_v", {31'd0, instr_valid}, 32'd1);
            chk("hold_instr", instr, word_at(32'h0C));
            chk("hold_pc", instr_pc, 32'h0C);
            chk("hold_addr", mem_addr, 32'h0C);
            chk("hold_fc", {16'd0, fetch_count}, 32'd2);
        end
        sb_q.push_back(32'h0C);
        instr_ready = 1'b1;
        step(1);
        chk("x2_fc", {16'd0, fetch_count}, 32'd3);
        chk("x2_addr", mem_addr, 32'h10);

        redirect_en = 1'b1;
        redirect_pc = 32'h24;
        sb_q.push_back(32'h24);
        step(1);
        redirect_en = 1'b0;
        wait_valid("end_valid", 8);
        chk("end_pc", instr_pc, 32'h24);
        step(1);
        chk("halt_h", {31'd0, halted}, 32'd1);
        chk("halt_v", {31'd0, instr_valid}, 32'd0);
        chk("halt_fc", {16'd0, fetch_count}, 32'd4);
        step(3);
        chk("halt_stay", {31'd0, halted}, 32'd1);
        chk("halt_stay_v", {31'd0, instr_valid}, 32'd0);

        redirect_en = 1'b1;
        redirect_pc = 32'h0;
        sb_q.push_back(32'h00);
        step(1);
        redirect_en = 1'b0;
        instr_ready = 1'b0;
        chk("unh_h", {31'd0, halted}, 32'd0);
        chk("unh_addr", mem_addr, 32'h0);
        wait_valid("unh_valid", 8);
        chk("unh_instr", instr, 32'h58000000);

        instr_ready = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 32'h10;
        step(1);
        redirect_en = 1'b0;
        instr_ready = 1'b0;
        chk("rx_fc", {16'd0, fetch_count}, 32'd5);
        chk("rx_addr", mem_addr, 32'h10);
        chk("rx_valid", {31'd0, instr_valid}, 32'd0);
        wait_valid("rx_w_valid", 8);
        chk("rx_w_pc", instr_pc, 32'h10);

        instr_ready = 1'b1;
        rst_n = 1'b0;
        step(1);
        chk("r2_valid", {31'd0, instr_valid}, 32'd0);
        chk("r2_instr", instr, 32'd0);
        chk("r2_ipc", instr_pc, 32'd0);
        chk("r2_halted", {31'd0, halted}, 32'd0);
        chk("r2_fc", {16'd0, fetch_count}, 32'd0);
        chk("r2_addr", mem_addr, 32'd0);
        rst_n = 1'b1;
        step(1);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
